// File: rtl/dmem_stream_reader.sv
// Streams DEPTH consecutive 32-bit words from a data-memory read port, starting at BASE_ADDR,
// through a valid/ready output, one run per rising edge of the start level.
module dmem_stream_reader #(
  parameter int unsigned DEPTH     = 129600,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rd,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done
);

  localparam int unsigned CntW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(DEPTH - 1);
  localparam logic [31:0] BaseAddr = 32'(BASE_ADDR);

  typedef enum logic [1:0] {StIdle, StFetch, StSend, StDone} state_e;

  state_e          state_q, state_d;
  logic            start_q, start_prev_q;
  logic [31:0]     addr_q, addr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [31:0]     out_data_q, out_data_d;
  logic            out_valid_q, out_valid_d;
  logic            start_rise;

  // start is sampled first, then compared against its previous sample
  assign start_rise = start_q & ~start_prev_q;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    count_d     = count_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      StIdle: begin
        if (start_rise) begin
          addr_d  = BaseAddr;
          count_d = '0;
          state_d = StFetch;
        end
      end
      StFetch: begin
        out_data_d  = mem_rd;
        out_valid_d = 1'b1;
        state_d     = StSend;
      end
      StSend: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          if (count_q == LastCnt) begin
            state_d = StDone;
          end else begin
            addr_d  = addr_q + 32'd1;
            count_d = count_q + CntW'(1);
            state_d = StFetch;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      start_q      <= 1'b0;
      start_prev_q <= 1'b0;
      addr_q       <= BaseAddr;
      count_q      <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_q      <= start;
      start_prev_q <= start_q;
      addr_q       <= addr_d;
      count_q      <= count_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
    end
  end

  assign mem_req   = (state_q == StFetch) || (state_q == StSend);
  assign mem_addr  = addr_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);

endmodule

// File: tb/tb_dmem_stream_reader.sv
// Self-checking bench for dmem_stream_reader: three instances (DEPTH 4, 1, 1000) checked against
// a handshake-level model of the expected word sequence and timing.
module tb_dmem_stream_reader;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // DEPTH=4, BASE_ADDR=0
  logic        start4 = 1'b0, ready4 = 1'b1;
  logic        req4, valid4, busy4, done4;
  logic [31:0] addr4, data4, rd4;
  logic [31:0] mem4 [16];
  assign rd4 = (addr4 < 32'd16) ? mem4[addr4[3:0]] : 32'hBAD0_0000;

  dmem_stream_reader #(.DEPTH(4), .BASE_ADDR(0)) u_dut4 (
    .clk(clk), .reset(reset), .start(start4), .mem_req(req4), .mem_addr(addr4), .mem_rd(rd4),
    .out_data(data4), .out_valid(valid4), .out_ready(ready4), .busy(busy4), .done(done4)
  );

  // DEPTH=1, BASE_ADDR=100
  logic        start1 = 1'b0, ready1 = 1'b1;
  logic        req1, valid1, busy1, done1;
  logic [31:0] addr1, data1, rd1;
  assign rd1 = (addr1 == 32'd100) ? 32'hDEAD_BEEF : 32'h0;

  dmem_stream_reader #(.DEPTH(1), .BASE_ADDR(100)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .mem_req(req1), .mem_addr(addr1), .mem_rd(rd1),
    .out_data(data1), .out_valid(valid1), .out_ready(ready1), .busy(busy1), .done(done1)
  );

  // DEPTH=1000, BASE_ADDR=7, memory word at address a is 3*a + 0x1000_0000
  logic        startl = 1'b0, readyl = 1'b1;
  logic        reql, validl, busyl, donel;
  logic [31:0] addrl, datal, rdl;
  assign rdl = addrl * 32'd3 + 32'h1000_0000;

  dmem_stream_reader #(.DEPTH(1000), .BASE_ADDR(7)) u_dutl (
    .clk(clk), .reset(reset), .start(startl), .mem_req(reql), .mem_addr(addrl), .mem_rd(rdl),
    .out_data(datal), .out_valid(validl), .out_ready(readyl), .busy(busyl), .done(donel)
  );

  // Handshake/done log of the DEPTH=4 instance
  logic [31:0] hs_data[$];
  logic [31:0] hs_addr[$];
  int          hs_cyc[$];
  int          done_cyc[$];
  int          stall_viol = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = '0;

  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (valid4 && ready4) begin
        hs_data.push_back(data4);
        hs_addr.push_back(addr4);
        hs_cyc.push_back(cyc);
      end
      if (done4) done_cyc.push_back(cyc);
      if (prev_stall && (!valid4 || data4 !== prev_data)) stall_viol = stall_viol + 1;
      prev_stall = valid4 && !ready4;
      prev_data  = data4;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    hs_data.delete();
    hs_addr.delete();
    hs_cyc.delete();
    done_cyc.delete();
    stall_viol = 0;
  endtask

  task automatic fill_a0();
    for (int i = 0; i < 16; i++) mem4[i] = 32'hA0 + 32'(i);
  endtask

  task automatic wait_done4(input int lim, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < lim; k++) begin
      step();
      if (done_cyc.size() > 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    n_checks++; if (valid4 !== 1'b0) $display("FAIL reset_valid got %b want 0", valid4); else n_pass++;
    n_checks++; if (data4 !== 32'h0) $display("FAIL reset_data got %h want 0", data4); else n_pass++;
    n_checks++; if (req4 !== 1'b0) $display("FAIL reset_req got %b want 0", req4); else n_pass++;
    n_checks++; if (busy4 !== 1'b0) $display("FAIL reset_busy got %b want 0", busy4); else n_pass++;
    n_checks++; if (done4 !== 1'b0) $display("FAIL reset_done got %b want 0", done4); else n_pass++;
    n_checks++; if (addr1 !== 32'd100) $display("FAIL reset_base_addr got %0d want 100", addr1);
    else n_pass++;
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_basic();
    int s;
    bit ok;
    fill_a0();
    ready4 = 1'b1;
    clear_logs();
    step();
    start4 = 1'b1;
    s = cyc;
    step();
    start4 = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      #1;
      if (done4) begin
        ok = 1'b1;
        break;
      end
    end
    n_checks++; if (!ok) $display("FAIL basic_timeout got no done want done"); else n_pass++;
    n_checks++; if (busy4 !== 1'b1) $display("FAIL basic_busy_in_done got %b want 1", busy4);
    else n_pass++;
    @(negedge clk);
    #1;
    n_checks++; if (busy4 !== 1'b0) $display("FAIL basic_busy_after got %b want 0", busy4);
    else n_pass++;
    n_checks++; if (hs_data.size() != 4) $display("FAIL basic_count got %0d want 4", hs_data.size());
    else n_pass++;
    for (int i = 0; i < hs_data.size() && i < 4; i++) begin
      n_checks++;
      if (hs_data[i] !== 32'hA0 + 32'(i)) $display("FAIL basic_data[%0d] got %h want %h", i,
                                                   hs_data[i], 32'hA0 + 32'(i));
      else n_pass++;
      n_checks++;
      if (hs_cyc[i] != s + 3 + 2 * i) $display("FAIL basic_hs_cycle[%0d] got %0d want %0d", i,
                                             hs_cyc[i] - s, 3 + 2 * i);
      else n_pass++;
    end
    n_checks++;
    if (done_cyc.size() != 1 || done_cyc[0] != s + 10)
      $display("FAIL basic_done_cycle got n=%0d want one at +10", done_cyc.size());
    else n_pass++;
    step();
  endtask

  task automatic test_stall();
    bit ok;
    fill_a0();
    ready4 = 1'b1;
    clear_logs();
    step();
    start4 = 1'b1;
    step();
    start4 = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      #1;
      if (req4 && !valid4 && addr4 == 32'd2) break;
    end
    step();
    ready4 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_checks++; if (valid4 !== 1'b1) $display("FAIL stall_valid[%0d] got %b want 1", k, valid4);
      else n_pass++;
      n_checks++; if (data4 !== 32'hA2) $display("FAIL stall_data[%0d] got %h want a2", k, data4);
      else n_pass++;
      n_checks++; if (addr4 !== 32'd2) $display("FAIL stall_addr[%0d] got %0d want 2", k, addr4);
      else n_pass++;
    end
    step();
    ready4 = 1'b1;
    wait_done4(40, ok);
    n_checks++; if (!ok) $display("FAIL stall_timeout got no done want done"); else n_pass++;
    n_checks++; if (hs_data.size() != 4) $display("FAIL stall_count got %0d want 4", hs_data.size());
    else n_pass++;
    for (int i = 0; i < hs_data.size() && i < 4; i++) begin
      n_checks++;
      if (hs_data[i] !== 32'hA0 + 32'(i)) $display("FAIL stall_seq[%0d] got %h want %h", i,
                                                   hs_data[i], 32'hA0 + 32'(i));
      else n_pass++;
    end
    step();
  endtask

  task automatic test_random();
    logic [31:0] exp [4];
    bit ok;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 4; i++) begin
        mem4[i] = $urandom;
        exp[i]  = mem4[i];
      end
      clear_logs();
      step();
      start4 = 1'b1;
      step();
      start4 = 1'b0;
      ok = 1'b0;
      for (int k = 0; k < 300; k++) begin
        ready4 = 1'($urandom_range(0, 1));
        step();
        if (done_cyc.size() > 0) begin
          ok = 1'b1;
          break;
        end
      end
      ready4 = 1'b1;
      repeat (3) step();
      n_checks++; if (!ok) $display("FAIL rand_timeout[%0d] got no done want done", r); else n_pass++;
      n_checks++;
      if (hs_data.size() != 4) $display("FAIL rand_count[%0d] got %0d want 4", r, hs_data.size());
      else n_pass++;
      for (int i = 0; i < hs_data.size() && i < 4; i++) begin
        n_checks++;
        if (hs_data[i] !== exp[i] || hs_addr[i] !== 32'(i))
          $display("FAIL rand_word[%0d][%0d] got %h@%0d want %h@%0d", r, i, hs_data[i],
                   hs_addr[i], exp[i], i);
        else n_pass++;
      end
      n_checks++; if (stall_viol != 0) $display("FAIL rand_stable[%0d] got %0d want 0", r, stall_viol);
      else n_pass++;
      n_checks++;
      if (done_cyc.size() != 1) $display("FAIL rand_done[%0d] got %0d want 1", r, done_cyc.size());
      else n_pass++;
    end
  endtask

  task automatic test_restart_ignored();
    bit ok;
    fill_a0();
    ready4 = 1'b1;
    clear_logs();
    step();
    start4 = 1'b1;
    step();
    start4 = 1'b0;
    for (int k = 0; k < 20 && hs_data.size() < 1; k++) step();
    start4 = 1'b1;
    wait_done4(40, ok);
    repeat (8) step();
    start4 = 1'b0;
    n_checks++; if (!ok) $display("FAIL restart_timeout got no done want done"); else n_pass++;
    n_checks++;
    if (hs_data.size() != 4) $display("FAIL restart_count got %0d want 4", hs_data.size());
    else n_pass++;
    n_checks++;
    if (done_cyc.size() != 1) $display("FAIL restart_done got %0d want 1", done_cyc.size());
    else n_pass++;
    n_checks++;
    if (hs_data.size() > 0 && hs_data[hs_data.size()-1] !== 32'hA3)
      $display("FAIL restart_last got %h want a3", hs_data[hs_data.size()-1]);
    else n_pass++;
    step();
  endtask

  task automatic test_reset_mid();
    bit ok;
    fill_a0();
    ready4 = 1'b1;
    clear_logs();
    step();
    start4 = 1'b1;
    step();
    start4 = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      #1;
      if (req4 && !valid4 && addr4 == 32'd2) break;
    end
    step();
    ready4 = 1'b0;
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({req4, valid4, busy4, done4} !== 4'b0000)
      $display("FAIL midreset_ctrl got %b want 0000", {req4, valid4, busy4, done4});
    else n_pass++;
    n_checks++;
    if (data4 !== 32'h0 || addr4 !== 32'h0)
      $display("FAIL midreset_data got %h/%h want 0/0", data4, addr4);
    else n_pass++;
    step();
    step();
    reset = 1'b0;
    ready4 = 1'b1;
    repeat (4) step();
    n_checks++; if (done_cyc.size() != 0) $display("FAIL midreset_nodone got %0d want 0",
                                                 done_cyc.size());
    else n_pass++;
    clear_logs();
    start4 = 1'b1;
    step();
    start4 = 1'b0;
    wait_done4(40, ok);
    n_checks++; if (!ok) $display("FAIL midreset_timeout got no done want done"); else n_pass++;
    n_checks++;
    if (hs_data.size() != 4 || hs_addr[0] !== 32'd0 || hs_data[0] !== 32'hA0)
      $display("FAIL midreset_restart got n=%0d want 4 words from addr 0", hs_data.size());
    else n_pass++;
    step();
  endtask

  task automatic test_depth1();
    int words, dones;
    words = 0;
    dones = 0;
    ready1 = 1'b1;
    step();
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (req1) begin
        n_checks++; if (addr1 !== 32'd100) $display("FAIL d1_addr got %0d want 100", addr1);
        else n_pass++;
      end
      if (valid1 && ready1) begin
        words++;
        n_checks++; if (data1 !== 32'hDEAD_BEEF) $display("FAIL d1_data got %h want deadbeef", data1);
        else n_pass++;
      end
      if (done1) dones++;
    end
    n_checks++; if (words != 1) $display("FAIL d1_words got %0d want 1", words); else n_pass++;
    n_checks++; if (dones != 1) $display("FAIL d1_done got %0d want 1", dones); else n_pass++;
    step();
  endtask

  task automatic test_long();
    int s, n, done_at;
    n = 0;
    done_at = -1;
    readyl = 1'b1;
    step();
    startl = 1'b1;
    s = cyc;
    step();
    startl = 1'b0;
    for (int k = 0; k < 2100; k++) begin
      @(negedge clk);
      if (validl && readyl) begin
        n_checks++;
        if (addrl !== 32'(7 + n) || datal !== 32'(7 + n) * 32'd3 + 32'h1000_0000)
          $display("FAIL long_word[%0d] got %h@%0d want %h@%0d", n, datal, addrl,
                   32'(7 + n) * 32'd3 + 32'h1000_0000, 7 + n);
        else n_pass++;
        n++;
      end
      if (donel) begin
        done_at = cyc;
        break;
      end
    end
    n_checks++; if (n != 1000) $display("FAIL long_count got %0d want 1000", n); else n_pass++;
    n_checks++;
    if (done_at - (s + 1) != 2001) $display("FAIL long_done_latency got %0d want 2001",
                                            done_at - (s + 1));
    else n_pass++;
    step();
  endtask

  initial begin
    fill_a0();
    test_reset();
    test_basic();
    test_stall();
    test_random();
    test_restart_ignored();
    test_reset_mid();
    test_depth1();
    test_long();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dmem_stream_reader.md
DMEM_STREAM_READER -- requirements
Module: dmem_stream_reader

Interface
REQ-001 SHALL have parameter DEPTH, default 129600: number of 32-bit words read per run.
REQ-002 SHALL have parameter BASE_ADDR, default 0: word address of the first word read.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: level switch; a rising edge requests one readout run.
REQ-006 SHALL have port mem_req, output, 1: high while the block owns the data-memory read port.
REQ-007 SHALL have port mem_addr, output, 32: word address presented to the data memory.
REQ-008 SHALL have port mem_rd, input, 32: combinational read data returned for mem_addr.
REQ-009 SHALL have port out_data, output, 32: registered word being streamed.
REQ-010 SHALL have port out_valid, output, 1: out_data holds a valid word.
REQ-011 SHALL have port out_ready, input, 1: downstream accepts out_data this cycle.
REQ-012 SHALL have port busy, output, 1: high from run start to the end of DONE.
REQ-013 SHALL have port done, output, 1: single-cycle pulse after the last word is accepted.

Function
REQ-014 SHALL register start internally; a run is triggered when the previous sample is 0 and the current sample is 1.
REQ-015 SHALL implement FSM states IDLE, FETCH, SEND, DONE.
REQ-016 IDLE: mem_req=0, busy=0, out_valid=0; on a start rising edge, load addr=BASE_ADDR and count=0, then go to FETCH.
REQ-017 FETCH: mem_req=1, mem_addr=addr; on the next edge, capture mem_rd into out_data, set out_valid=1, and go to SEND.
REQ-018 SEND: hold out_data and out_valid stable until out_valid&&out_ready; mem_req=1.
REQ-019 On a SEND handshake with count==DEPTH-1: clear out_valid and go to DONE.
REQ-020 On any other SEND handshake: increment addr and count, clear out_valid, and go to FETCH.
REQ-021 DONE: done=1 and busy=1 for exactly one cycle, then go to IDLE.
REQ-022 Throughput SHALL be one word per two cycles when out_ready is held high; latency from the start edge sample to first out_valid is 2 cycles.
REQ-023 count SHALL be $clog2(DEPTH) bits wide, with DEPTH>=1; addr SHALL be 32 bits; addr SHALL NOT wrap within a run.
REQ-024 With DEPTH=1, the run SHALL go IDLE->FETCH->SEND->DONE with a single word.
REQ-025 Start edges while busy=1 SHALL be ignored and not queued.
REQ-026 mem_addr SHALL equal addr in all states; it is a don't-care when mem_req=0.
REQ-027 out_ready while out_valid=0 SHALL have no effect.
REQ-028 Words SHALL be emitted in strictly ascending address order, with none skipped or duplicated regardless of out_ready stalls.

Reset
REQ-029 Reset SHALL force state=IDLE, addr=BASE_ADDR, count=0, out_data=0, out_valid=0, mem_req=0, busy=0, done=0, and the start sample register to 0.
REQ-030 Reset asserted mid-run SHALL abort the run immediately with no done pulse.
REQ-031 After reset release, a start held high SHALL count as a rising edge on the first sampled clock.

Verification
REQ-032 DEPTH=4, BASE_ADDR=0, memory word i = 0xA0+i, out_ready=1, start pulse -> out_data sequence 0xA0..0xA3 on 4 handshakes 2 cycles apart, done pulse one cycle after the 4th handshake, busy falls the cycle after.
REQ-033 Same setup, out_ready low for 5 cycles at word 2 -> out_data=0xA2 and out_valid stay stable for all 5 cycles, mem_addr=2, and the sequence stays intact.
REQ-034 DEPTH=1, BASE_ADDR=100, mem[100]=0xDEADBEEF -> one word 0xDEADBEEF, then done; mem_addr=100 throughout.
REQ-035 Second start edge during a run at word 1 -> no restart, exactly 4 words, one done pulse.
REQ-036 Reset asserted while in SEND at word 2 -> all outputs 0 within the same cycle, no done; a later start edge restarts at BASE_ADDR.
REQ-037 DEPTH=129600 full run with out_ready=1 -> 129600 handshakes, last mem_addr=129599, done asserted 259201 cycles after the start edge is sampled.
